// File: rtl/value_rank_sorter_pkg.sv
// ============================================================================
// value_rank_sorter_pkg : shared constants, state encoding and slot record
// Rev 1.0
// ============================================================================
`default_nettype none

package value_rank_sorter_pkg;

    localparam int N_IMG   = 8;
    localparam int VAL_W   = 23;
    localparam int ID_W    = 3;
    localparam int CNT_W   = ID_W + 1;
    localparam int STATE_W = 1;

    localparam logic [STATE_W-1:0] FILL  = 1'b0;
    localparam logic [STATE_W-1:0] DRAIN = 1'b1;

    typedef struct packed {
        logic [ID_W-1:0]  id;
        logic [VAL_W-1:0] value;
    } slot_t;

    typedef enum logic [1:0] {
        OP_HOLD  = 2'd0,
        OP_LOAD  = 2'd1,
        OP_ABOVE = 2'd2,
        OP_BELOW = 2'd3
    } slot_op_t;

endpackage

`default_nettype wire

// File: rtl/value_rank_sorter_if.sv
// ============================================================================
// value_rank_sorter_if : capture / drain handshake bundle of the rank sorter
// Rev 1.0
// ============================================================================
`default_nettype none

interface value_rank_sorter_if;
    import value_rank_sorter_pkg::*;

    logic             in_valid;
    logic [VAL_W-1:0] in_value;
    logic [ID_W-1:0]  in_id;
    logic             in_ready;
    logic             sort_done;
    logic             out_valid;
    logic             out_ready;
    logic [ID_W-1:0]  out_id;
    logic [VAL_W-1:0] out_value;
    logic             out_last;
    logic [CNT_W-1:0] count;
    logic             busy;

    modport master (
        output in_valid, in_value, in_id, sort_done, out_ready,
        input  in_ready, out_valid, out_id, out_value, out_last, count, busy
    );

    modport slave (
        input  in_valid, in_value, in_id, sort_done, out_ready,
        output in_ready, out_valid, out_id, out_value, out_last, count, busy
    );

endinterface

`default_nettype wire

// File: rtl/value_rank_sorter_rank_slot.sv
// ============================================================================
// rank_slot : one {id, value} entry with hold / load / shift-down / shift-up
// Rev 1.0
// ============================================================================
`default_nettype none

module rank_slot
    import value_rank_sorter_pkg::*;
(
    input  wire logic clk,
    input  wire logic rst,
    input  slot_op_t  op_i,
    input  slot_t     new_i,
    input  slot_t     above_i,
    input  slot_t     below_i,
    output slot_t     entry_o
);

    slot_t entry_q;
    slot_t entry_d;

    always_comb begin
        entry_d = entry_q;
        unique case (op_i)
            OP_LOAD:  entry_d = new_i;
            OP_ABOVE: entry_d = above_i;
            OP_BELOW: entry_d = below_i;
            default:  entry_d = entry_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            entry_q <= '0;
        end else begin
            entry_q <= entry_d;
        end
    end

    assign entry_o = entry_q;

endmodule

`default_nettype wire

// File: rtl/value_rank_sorter.sv
// ============================================================================
// value_rank_sorter : keeps captured colour values in descending order and
// streams them out largest-first on a drain request
// Rev 1.0
// ============================================================================
`default_nettype none

module value_rank_sorter
    import value_rank_sorter_pkg::*;
(
    input  wire logic          clk,
    input  wire logic          rst,
    value_rank_sorter_if.slave bus
);

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_d;
    slot_t              slot_q [N_IMG];
    slot_op_t           slot_op [N_IMG];
    logic [N_IMG-1:0]   lt;
    logic [N_IMG-1:0]   lt_prev;
    slot_t              new_entry;
    logic               accept;
    logic               pop;

    assign new_entry = '{id: bus.in_id, value: bus.in_value};
    assign accept    = (state_q == FILL) && bus.in_valid && (count_q < CNT_W'(N_IMG));
    assign pop       = (state_q == DRAIN) && bus.out_ready;

    // Unoccupied slots count as "smaller" so a zero value still lands after the tail.
    always_comb begin
        for (int i = 0; i < N_IMG; i++) begin
            lt[i] = (CNT_W'(i) >= count_q) || (slot_q[i].value < bus.in_value);
        end
    end

    assign lt_prev = {lt[N_IMG-2:0], 1'b0};

    always_comb begin
        for (int i = 0; i < N_IMG; i++) begin
            slot_op[i] = OP_HOLD;
            if (accept && lt[i]) begin
                slot_op[i] = lt_prev[i] ? OP_ABOVE : OP_LOAD;
            end else if (pop) begin
                slot_op[i] = OP_BELOW;
            end
        end
    end

    for (genvar i = 0; i < N_IMG; i++) begin : g_slot
        slot_t above;
        slot_t below;

        if (i == 0) begin : g_head
            assign above = '0;
        end else begin : g_body
            assign above = slot_q[i-1];
        end

        if (i == N_IMG - 1) begin : g_tail
            assign below = '0;
        end else begin : g_mid
            assign below = slot_q[i+1];
        end

        rank_slot u_slot (
            .clk     (clk),
            .rst     (rst),
            .op_i    (slot_op[i]),
            .new_i   (new_entry),
            .above_i (above),
            .below_i (below),
            .entry_o (slot_q[i])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= FILL;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        if (accept) begin
            count_d = count_q + 1'b1;
        end else if (pop) begin
            count_d = count_q - 1'b1;
        end
        case (state_q)
            FILL: begin
                if (bus.sort_done && ((count_q != '0) || accept)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && (count_q == CNT_W'(1))) begin
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_q == FILL) && (count_q < CNT_W'(N_IMG));
        bus.busy      = (state_q == DRAIN);
        bus.out_valid = (state_q == DRAIN);
        bus.out_last  = (state_q == DRAIN) && (count_q == CNT_W'(1));
        bus.out_id    = (state_q == DRAIN) ? slot_q[0].id    : '0;
        bus.out_value = (state_q == DRAIN) ? slot_q[0].value : '0;
        bus.count     = count_q;
    end

endmodule

`default_nettype wire

// File: doc/value_rank_sorter.md
Name: value_rank_sorter

Overview:
- Sits directly downstream of the per-image colour accumulator.
- Captures one 23-bit accumulated colour value per image, tagged with an image ID, and keeps all captured entries in descending order as they arrive (single-cycle parallel insertion).
- On a drain request it streams (ID, value) pairs out largest-first over a valid/ready handshake, feeding the engine's output/ranking stage.

Parameters:
- N_IMG, 8, maximum number of images held.
- VAL_W, 23, width of accumulated value (matches accumulator output).
- ID_W, 3, image ID width; must satisfy 2^ID_W >= N_IMG.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-low reset.
- in_valid  input  1  accumulated value presented for capture.
- in_value  input  VAL_W  accumulated colour value.
- in_id  input  ID_W  image ID for in_value.
- in_ready  output  1  block can accept an entry this cycle.
- sort_done  input  1  single-cycle pulse: no more entries, begin drain.
- out_valid  output  1  out_id/out_value hold a valid ranked entry.
- out_ready  input  1  consumer accepts the current entry.
- out_id  output  ID_W  ID of the current highest remaining entry.
- out_value  output  VAL_W  value of that entry.
- out_last  output  1  current output is the final entry.
- count  output  ID_W+1  number of entries held.
- busy  output  1  high while in DRAIN.

Behaviour:
- Reset (rst=0 at a clk edge): all slots cleared to value 0 and ID 0, count=0, state FILL, in_ready=1, out_valid=0, out_last=0, out_id=0, out_value=0, busy=0. Reset overrides every other input, including mid-drain.
- States: FILL and DRAIN only.
- FILL:
  - in_ready = (count < N_IMG).
  - Accept when in_valid && in_ready. The new entry is placed in sorted position in the same edge: every slot whose value is strictly less than in_value shifts down one place, and the new entry takes the freed slot. count increments. The updated order is visible on the next cycle.
  - Ties: a new entry goes after existing entries of equal value, so ordering is stable by arrival.
  - in_valid while full: ignored, with no state change.
  - sort_done with count > 0: go to DRAIN. sort_done with count == 0: ignored, stay in FILL.
  - in_valid and sort_done in the same cycle: the entry is inserted (if in_ready) and the state goes to DRAIN. The drain includes the new entry.
- DRAIN:
  - in_ready=0, busy=1, out_valid=1.
  - out_id/out_value = slot 0 (the head); out_last = (count == 1).
  - On out_valid && out_ready: all slots shift up one place, the vacated tail slot clears to 0, and count decrements.
  - While out_ready=0, outputs hold stable.
  - After the handshake on the out_last entry: count=0, state goes to FILL, out_valid=0 on the next cycle.
  - sort_done and in_valid are ignored in DRAIN.
- Output latency: first out_valid appears on the cycle after sort_done is sampled.
- Values are unsigned and compared at full VAL_W width. No arithmetic is performed and no overflow is possible.

Decomposition:
- Shared package (colour engine package):
  - VAL_W, ID_W and N_IMG constants.
  - State encoding constants FILL=1'b0, DRAIN=1'b1.
  - The slot record layout {id, value}.
- One sub-module, rank_slot: holds one {id, value} entry and selects between hold, load-new, take-from-above (insert shift) and take-from-below (drain shift). It receives the compare result from the top level.
- The top level instantiates N_IMG rank_slot instances and contains the FSM, count and handshake logic.

Test Plan:
1. Reset: hold rst=0 for 2 cycles -> count=0, in_ready=1, out_valid=0, busy=0, out_id=0, out_value=0.
2. Basic ranking:
   - Stimulus: insert (id0,159), (id1,314), (id2,50), then sort_done, with out_ready=1.
   - Response: outputs (1,314), (0,159), (2,50) on consecutive cycles; out_last only on the third; state returns to FILL with in_ready=1.
3. Tie stability: insert (id3,100), (id4,100), (id5,200), then drain -> order id5, id3, id4.
4. Full and empty boundaries:
   - Insert 8 entries with values 10,80,30,70,50,60,20,40 -> in_ready=0 and count=8.
   - A 9th in_valid leaves count at 8.
   - Drain gives 80,70,60,50,40,30,20,10.
   - sort_done with count=0 produces no out_valid.
5. Backpressure and simultaneous events:
   - Insert (id6,500) in the same cycle as sort_done -> busy=1 on the next cycle and head is (6,500).
   - With out_ready=0 for 3 cycles, out_id=6 and out_value=500 stay stable.
6. Reset mid-drain:
   - Stimulus: three entries held, rst=0 for one cycle after the first handshake.
   - Response: out_valid=0, count=0, busy=0, in_ready=1; a fresh insert (id7,9) followed by drain yields only (7,9) with out_last=1.
